// File: rtl/dmem_responder.sv
// Single-port word memory behind a valid/ready request/response handshake.
// One request outstanding at a time, with a fixed response delay of LATENCY+1 cycles.
module dmem_responder #(
    parameter int          DEPTH     = 1024,
    parameter int          LATENCY   = 2,
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [3:0]  req_be,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [31:0] resp_rdata,
    output logic        resp_err
);

    localparam int IDX_W = $clog2(DEPTH);

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_RESP
    } state_t;

    state_t      state_q;
    logic [3:0]  cnt_q;
    logic        req_ready_q;
    logic        resp_valid_q;
    logic [31:0] resp_rdata_q;
    logic        resp_err_q;

    logic [31:0] mem_q [DEPTH];

    logic [31:0]      word_idx_d;
    logic [IDX_W-1:0] mem_idx_d;
    logic             acc_err_d;
    logic             accept_d;
    logic [31:0]      rdata_d;

    // Subtraction wraps, so addresses below BASE_ADDR land far above DEPTH.
    always_comb begin
        word_idx_d = (req_addr - BASE_ADDR) >> 2;
        mem_idx_d  = word_idx_d[IDX_W-1:0];
        acc_err_d  = (req_addr[1:0] != 2'b00) || (word_idx_d >= 32'(DEPTH));
        accept_d   = !rst && (state_q == S_IDLE) && req_valid;
        rdata_d    = (!req_we && !acc_err_d) ? mem_q[mem_idx_d] : 32'h0;
    end

    always_ff @(posedge clk) begin
        if (accept_d && req_we && !acc_err_d) begin
            for (int b = 0; b < 4; b++) begin
                if (req_be[b]) begin
                    mem_q[mem_idx_d][8*b +: 8] <= req_wdata[8*b +: 8];
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_IDLE;
            cnt_q        <= 4'd0;
            req_ready_q  <= 1'b1;
            resp_valid_q <= 1'b0;
            resp_rdata_q <= 32'h0;
            resp_err_q   <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (req_valid) begin
                        req_ready_q  <= 1'b0;
                        resp_rdata_q <= rdata_d;
                        resp_err_q   <= acc_err_d;
                        if (LATENCY == 0) begin
                            state_q      <= S_RESP;
                            resp_valid_q <= 1'b1;
                        end else begin
                            state_q <= S_WAIT;
                            cnt_q   <= 4'(LATENCY);
                        end
                    end
                end
                S_WAIT: begin
                    if (cnt_q == 4'd1) begin
                        state_q      <= S_RESP;
                        cnt_q        <= 4'd0;
                        resp_valid_q <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q - 4'd1;
                    end
                end
                S_RESP: begin
                    if (resp_ready) begin
                        state_q      <= S_IDLE;
                        req_ready_q  <= 1'b1;
                        resp_valid_q <= 1'b0;
                        resp_rdata_q <= 32'h0;
                        resp_err_q   <= 1'b0;
                    end
                end
                default: begin
                    state_q      <= S_IDLE;
                    cnt_q        <= 4'd0;
                    req_ready_q  <= 1'b1;
                    resp_valid_q <= 1'b0;
                    resp_rdata_q <= 32'h0;
                    resp_err_q   <= 1'b0;
                end
            endcase
        end
    end

    assign req_ready  = req_ready_q;
    assign resp_valid = resp_valid_q;
    assign resp_rdata = resp_rdata_q;
    assign resp_err   = resp_err_q;

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench: a LATENCY=2 instance at base 0 and a LATENCY=0 instance at base 0x1000.
module tb_dmem_responder;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst = 1'b0;

    logic        req_valid = 1'b0, req_we = 1'b0, resp_ready = 1'b0;
    logic [31:0] req_addr = 32'h0, req_wdata = 32'h0;
    logic [3:0]  req_be = 4'h0;
    logic        req_ready, resp_valid, resp_err;
    logic [31:0] resp_rdata;

    logic        req_valid0 = 1'b0, req_we0 = 1'b0, resp_ready0 = 1'b0;
    logic [31:0] req_addr0 = 32'h0, req_wdata0 = 32'h0;
    logic [3:0]  req_be0 = 4'h0;
    logic        req_ready0, resp_valid0, resp_err0;
    logic [31:0] resp_rdata0;

    int total = 0;
    int bad = 0;

    dmem_responder #(.DEPTH(1024), .LATENCY(2), .BASE_ADDR(32'h0000_0000)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_be(req_be),
        .resp_valid(resp_valid), .resp_ready(resp_ready),
        .resp_rdata(resp_rdata), .resp_err(resp_err)
    );

    dmem_responder #(.DEPTH(16), .LATENCY(0), .BASE_ADDR(32'h0000_1000)) dut0 (
        .clk(clk), .rst(rst),
        .req_valid(req_valid0), .req_ready(req_ready0), .req_we(req_we0),
        .req_addr(req_addr0), .req_wdata(req_wdata0), .req_be(req_be0),
        .resp_valid(resp_valid0), .resp_ready(resp_ready0),
        .resp_rdata(resp_rdata0), .resp_err(resp_err0)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Full transaction on one instance; lat = edges from acceptance to first edge seeing resp_valid.
    task automatic do_req(input bit d0, input bit we, input logic [31:0] addr,
                          input logic [31:0] wdata, input logic [3:0] be,
                          output logic [31:0] rdata, output logic err, output int lat);
        int n;
        if (d0) begin
            req_valid0 = 1'b1; req_we0 = we; req_addr0 = addr; req_wdata0 = wdata; req_be0 = be;
        end else begin
            req_valid = 1'b1; req_we = we; req_addr = addr; req_wdata = wdata; req_be = be;
        end
        n = 0;
        while (!(d0 ? req_ready0 : req_ready) && n < 50) begin
            step();
            n++;
        end
        total++;
        if (n >= 50) begin
            bad++;
            $display("FAIL accept_timeout addr=%h: req_ready never 1, required 1", addr);
        end
        step();
        req_valid0 = 1'b0;
        req_valid  = 1'b0;
        lat = 1;
        while (!(d0 ? resp_valid0 : resp_valid) && lat < 50) begin
            step();
            lat++;
        end
        rdata = d0 ? resp_rdata0 : resp_rdata;
        err   = d0 ? resp_err0 : resp_err;
        if (d0) resp_ready0 = 1'b1; else resp_ready = 1'b1;
        step();
        resp_ready0 = 1'b0;
        resp_ready  = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
        total += 4;
        if (req_ready !== 1'b1) begin bad++; $display("FAIL rst_req_ready got=%b want=1", req_ready); end
        if (resp_valid !== 1'b0) begin bad++; $display("FAIL rst_resp_valid got=%b want=0", resp_valid); end
        if (resp_rdata !== 32'h0) begin bad++; $display("FAIL rst_resp_rdata got=%h want=0", resp_rdata); end
        if (resp_err !== 1'b0) begin bad++; $display("FAIL rst_resp_err got=%b want=0", resp_err); end
    endtask

    task automatic test_write_read();
        logic [31:0] rd; logic er; int lat;
        do_req(1'b0, 1'b1, 32'h10, 32'hDEADBEEF, 4'hF, rd, er, lat);
        total += 3;
        if (lat != 3) begin bad++; $display("FAIL wr_latency got=%0d want=3", lat); end
        if (er !== 1'b0) begin bad++; $display("FAIL wr_err got=%b want=0", er); end
        if (rd !== 32'h0) begin bad++; $display("FAIL wr_rdata got=%h want=0", rd); end
        do_req(1'b0, 1'b0, 32'h10, 32'h0, 4'h0, rd, er, lat);
        total += 3;
        if (lat != 3) begin bad++; $display("FAIL rd_latency got=%0d want=3", lat); end
        if (er !== 1'b0) begin bad++; $display("FAIL rd_err got=%b want=0", er); end
        if (rd !== 32'hDEADBEEF) begin bad++; $display("FAIL rd_data got=%h want=deadbeef", rd); end
    endtask

    task automatic test_byte_enable();
        logic [31:0] rd; logic er; int lat;
        do_req(1'b0, 1'b1, 32'h10, 32'h11223344, 4'b0101, rd, er, lat);
        do_req(1'b0, 1'b0, 32'h10, 32'h0, 4'h0, rd, er, lat);
        total++;
        if (rd !== 32'hDE22BE44) begin bad++; $display("FAIL be_merge got=%h want=de22be44", rd); end
        do_req(1'b0, 1'b1, 32'h10, 32'hFFFFFFFF, 4'h0, rd, er, lat);
        total++;
        if (er !== 1'b0) begin bad++; $display("FAIL be_zero_err got=%b want=0", er); end
        do_req(1'b0, 1'b0, 32'h10, 32'h0, 4'h0, rd, er, lat);
        total++;
        if (rd !== 32'hDE22BE44) begin bad++; $display("FAIL be_zero_noop got=%h want=de22be44", rd); end
    endtask

    task automatic test_errors();
        logic [31:0] rd; logic er; int lat;
        do_req(1'b0, 1'b0, 32'h13, 32'h0, 4'hF, rd, er, lat);
        total += 3;
        if (er !== 1'b1) begin bad++; $display("FAIL misalign_err got=%b want=1", er); end
        if (rd !== 32'h0) begin bad++; $display("FAIL misalign_rdata got=%h want=0", rd); end
        if (lat != 3) begin bad++; $display("FAIL misalign_latency got=%0d want=3", lat); end
        do_req(1'b0, 1'b0, 32'h1000, 32'h0, 4'hF, rd, er, lat);
        total += 2;
        if (er !== 1'b1) begin bad++; $display("FAIL range_err got=%b want=1", er); end
        if (rd !== 32'h0) begin bad++; $display("FAIL range_rdata got=%h want=0", rd); end
        do_req(1'b0, 1'b1, 32'h0, 32'h12345678, 4'hF, rd, er, lat);
        do_req(1'b0, 1'b1, 32'h1000, 32'hA5A5A5A5, 4'hF, rd, er, lat);
        total++;
        if (er !== 1'b1) begin bad++; $display("FAIL range_wr_err got=%b want=1", er); end
        do_req(1'b0, 1'b0, 32'h0, 32'h0, 4'h0, rd, er, lat);
        total++;
        if (rd !== 32'h12345678) begin bad++; $display("FAIL range_wr_alias got=%h want=12345678", rd); end
        do_req(1'b0, 1'b1, 32'hFFC, 32'h0BADF00D, 4'hF, rd, er, lat);
        do_req(1'b0, 1'b0, 32'hFFC, 32'h0, 4'h0, rd, er, lat);
        total += 2;
        if (er !== 1'b0) begin bad++; $display("FAIL last_word_err got=%b want=0", er); end
        if (rd !== 32'h0BADF00D) begin bad++; $display("FAIL last_word_data got=%h want=0badf00d", rd); end
    endtask

    task automatic test_backpressure();
        logic [31:0] rd; logic er; int lat; int n;
        req_valid = 1'b1; req_we = 1'b0; req_addr = 32'h10; req_be = 4'h0;
        step();
        req_valid = 1'b0;
        n = 0;
        while (!resp_valid && n < 50) begin step(); n++; end
        total++;
        if (!resp_valid) begin bad++; $display("FAIL bp_resp_timeout got=0 want=1"); end
        req_valid = 1'b1; req_we = 1'b1; req_addr = 32'h10; req_wdata = 32'h77777777; req_be = 4'hF;
        for (int i = 0; i < 5; i++) begin
            step();
            total += 3;
            if (resp_valid !== 1'b1) begin bad++; $display("FAIL bp_valid cyc=%0d got=%b want=1", i, resp_valid); end
            if (resp_rdata !== 32'hDE22BE44) begin bad++; $display("FAIL bp_rdata cyc=%0d got=%h want=de22be44", i, resp_rdata); end
            if (req_ready !== 1'b0) begin bad++; $display("FAIL bp_req_ready cyc=%0d got=%b want=0", i, req_ready); end
        end
        resp_ready = 1'b1;
        step();
        resp_ready = 1'b0;
        total += 2;
        if (resp_valid !== 1'b0) begin bad++; $display("FAIL bp_hs_valid got=%b want=0", resp_valid); end
        if (req_ready !== 1'b1) begin bad++; $display("FAIL bp_hs_req_ready got=%b want=1", req_ready); end
        step();
        req_valid = 1'b0;
        total++;
        if (req_ready !== 1'b0) begin bad++; $display("FAIL bp_second_accept got=%b want=0", req_ready); end
        n = 0;
        while (!resp_valid && n < 50) begin step(); n++; end
        total += 2;
        if (resp_err !== 1'b0) begin bad++; $display("FAIL bp_wr_err got=%b want=0", resp_err); end
        if (resp_rdata !== 32'h0) begin bad++; $display("FAIL bp_wr_rdata got=%h want=0", resp_rdata); end
        resp_ready = 1'b1;
        step();
        resp_ready = 1'b0;
        do_req(1'b0, 1'b0, 32'h10, 32'h0, 4'h0, rd, er, lat);
        total++;
        if (rd !== 32'h77777777) begin bad++; $display("FAIL bp_wr_commit got=%h want=77777777", rd); end
    endtask

    task automatic test_reset_mid_wait();
        logic [31:0] rd; logic er; int lat; int seen;
        req_valid = 1'b1; req_we = 1'b1; req_addr = 32'h20; req_wdata = 32'hCAFEBABE; req_be = 4'hF;
        step();
        req_valid = 1'b0;
        rst = 1'b1;
        step();
        rst = 1'b0;
        total += 2;
        if (req_ready !== 1'b1) begin bad++; $display("FAIL midwait_req_ready got=%b want=1", req_ready); end
        if (resp_valid !== 1'b0) begin bad++; $display("FAIL midwait_valid got=%b want=0", resp_valid); end
        seen = 0;
        for (int i = 0; i < 6; i++) begin
            step();
            if (resp_valid === 1'b1) seen++;
        end
        total++;
        if (seen != 0) begin bad++; $display("FAIL midwait_no_resp got=%0d want=0", seen); end
        rst = 1'b1;
        req_valid = 1'b1; req_we = 1'b1; req_addr = 32'h20; req_wdata = 32'h0; req_be = 4'hF;
        step();
        rst = 1'b0;
        req_valid = 1'b0;
        total++;
        if (req_ready !== 1'b1) begin bad++; $display("FAIL rst_priority_ready got=%b want=1", req_ready); end
        do_req(1'b0, 1'b0, 32'h20, 32'h0, 4'h0, rd, er, lat);
        total++;
        if (rd !== 32'hCAFEBABE) begin bad++; $display("FAIL midwait_commit got=%h want=cafebabe", rd); end
    endtask

    task automatic test_latency0();
        logic [31:0] rd; logic er; int lat; int acc; int last; int gap_bad;
        do_req(1'b1, 1'b1, 32'h1004, 32'h0F0F0F0F, 4'hF, rd, er, lat);
        total += 2;
        if (lat != 1) begin bad++; $display("FAIL l0_wr_latency got=%0d want=1", lat); end
        if (er !== 1'b0) begin bad++; $display("FAIL l0_wr_err got=%b want=0", er); end
        do_req(1'b1, 1'b0, 32'h1004, 32'h0, 4'h0, rd, er, lat);
        total += 2;
        if (lat != 1) begin bad++; $display("FAIL l0_rd_latency got=%0d want=1", lat); end
        if (rd !== 32'h0F0F0F0F) begin bad++; $display("FAIL l0_rd_data got=%h want=0f0f0f0f", rd); end
        do_req(1'b1, 1'b0, 32'h0FFC, 32'h0, 4'h0, rd, er, lat);
        total += 2;
        if (er !== 1'b1) begin bad++; $display("FAIL l0_below_base_err got=%b want=1", er); end
        if (rd !== 32'h0) begin bad++; $display("FAIL l0_below_base_rdata got=%h want=0", rd); end
        do_req(1'b1, 1'b0, 32'h1040, 32'h0, 4'h0, rd, er, lat);
        total++;
        if (er !== 1'b1) begin bad++; $display("FAIL l0_range_err got=%b want=1", er); end
        req_valid0 = 1'b1; req_we0 = 1'b0; req_addr0 = 32'h1004; resp_ready0 = 1'b1;
        acc = 0; last = -1; gap_bad = 0;
        for (int i = 0; i < 12; i++) begin
            if (req_ready0) begin
                acc++;
                if (last >= 0 && i - last != 2) gap_bad++;
                last = i;
            end
            step();
        end
        req_valid0 = 1'b0;
        resp_ready0 = 1'b0;
        step();
        total += 2;
        if (acc != 6) begin bad++; $display("FAIL l0_b2b_count got=%0d want=6", acc); end
        if (gap_bad != 0) begin bad++; $display("FAIL l0_b2b_gap got=%0d want=0", gap_bad); end
    endtask

    initial begin
        test_reset();
        test_write_read();
        test_byte_enable();
        test_errors();
        test_backpressure();
        test_reset_mid_wait();
        test_latency0();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/dmem_responder.md
DMEM_RESPONDER -- requirements
Module: dmem_responder

Interface
REQ-001 Parameter DEPTH, default 1024, SHALL be the number of 32-bit words stored (power of two, 4..65536).
REQ-002 Parameter LATENCY, default 2, SHALL be the extra wait cycles between request acceptance and response (0..15).
REQ-003 Parameter BASE_ADDR, default 32'h0000_0000, SHALL be the byte address of word 0 (word-aligned).
REQ-004 clk  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-005 rst  input  1  SHALL be a synchronous, active-high reset, sampled on the rising edge of clk.
REQ-006 req_valid  input  1  SHALL mean the initiator presents a request.
REQ-007 req_ready  output  1  SHALL mean the responder can accept a request this cycle.
REQ-008 req_we  input  1  SHALL select write (1) or read (0).
REQ-009 req_addr  input  32  SHALL be the byte address.
REQ-010 req_wdata  input  32  SHALL be the write data, little-endian byte lanes.
REQ-011 req_be  input  4  SHALL be the write byte enables; bit i covers req_wdata[8i+7:8i].
REQ-012 resp_valid  output  1  SHALL mean a response is presented.
REQ-013 resp_ready  input  1  SHALL mean the initiator accepts the response this cycle.
REQ-014 resp_rdata  output  32  SHALL be read data (0 for writes and errors).
REQ-015 resp_err  output  1  SHALL flag a rejected access.

Function
REQ-016 The block SHALL implement FSM states IDLE, WAIT, RESP; req_ready SHALL be 1 only in IDLE.
REQ-017 A request SHALL be accepted on an edge where state is IDLE and req_valid=1; at most one request is outstanding.
REQ-018 On acceptance: LATENCY=0 -> RESP; otherwise -> WAIT with a down-counter loaded with LATENCY.
REQ-019 In WAIT the counter SHALL decrement each cycle; the edge where it reads 1 moves to RESP, so resp_valid first rises LATENCY+1 cycles after the acceptance edge.
REQ-020 In RESP, resp_valid=1 and resp_rdata/resp_err SHALL be held stable until the edge with resp_ready=1, which returns to IDLE.
REQ-021 resp_ready while not in RESP SHALL be ignored; req_valid outside IDLE SHALL be ignored (no acceptance).
REQ-022 Word index = (req_addr - BASE_ADDR) >> 2, computed modulo 2^32.
REQ-023 Error SHALL be raised when req_addr[1:0] != 0 or word index >= DEPTH (including addresses below BASE_ADDR via wrap-around).
REQ-024 Valid write: the enabled bytes SHALL be written on the acceptance edge; disabled bytes unchanged; req_be=0 is a legal no-op, resp_err=0.
REQ-025 Valid read: the word SHALL be captured on the acceptance edge into a response register and returned unaltered; req_be ignored.
REQ-026 Errored access: no memory change, resp_rdata=0, resp_err=1, same timing as a valid access.
REQ-027 Write responses SHALL carry resp_rdata=0, resp_err=0 when valid.
REQ-028 Sustained throughput SHALL be one request per LATENCY+2 cycles with resp_ready held high.

Reset
REQ-029 rst=1 SHALL force state IDLE, counter 0, req_ready=1 on the following cycle, resp_valid=0, resp_rdata=0, resp_err=0.
REQ-030 Reset in WAIT or RESP SHALL discard the pending response; a write already committed at acceptance SHALL remain.
REQ-031 Memory contents SHALL not be cleared by reset (undefined after power-up).
REQ-032 rst SHALL take priority over any simultaneous request or response handshake.

Verification
REQ-033 LATENCY=2: write addr 0x10, wdata 0xDEADBEEF, be 4'hF at edge T -> resp_valid rises at T+3, resp_err=0; read 0x10 -> resp_rdata=0xDEADBEEF.
REQ-034 Byte enables: after word 0x10=0xDEADBEEF, write wdata 0x11223344, be 4'b0101 -> read returns 0xDE22BE44.
REQ-035 Errors: read 0x13 (misaligned) and read 4*DEPTH -> resp_err=1, resp_rdata=0; a write to 4*DEPTH leaves memory unchanged.
REQ-036 Backpressure: hold resp_ready=0 for 5 cycles in RESP -> resp_valid/resp_rdata stable, req_ready=0, a second req_valid not accepted until the cycle after the resp handshake.
REQ-037 LATENCY=0: accept at T -> resp_valid at T+1; back-to-back requests with resp_ready=1 are accepted every 2 cycles.
REQ-038 Reset mid-WAIT after write 0xCAFEBABE to 0x20 -> no response issued, req_ready=1 after reset, subsequent read of 0x20 returns 0xCAFEBABE.
